// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine issuing one SRAM-like request and registering raw results for WB
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [1:0]        in_size,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              flush,
  output logic              out_valid,
  input  logic              wb_allowin,
  output logic [DATA_W-1:0] wb_dmout,
  output logic [ADDR_W-1:0] wb_aluout,
  output logic              wb_adel,
  output logic              wb_ades,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state_q, state_d;
  logic discard_q, discard_d, ld_q, ld_d, out_valid_q, out_valid_d;
  logic [DATA_W-1:0] wb_dmout_q, wb_dmout_d, data_wdata_q, data_wdata_d;
  logic [ADDR_W-1:0] wb_aluout_q, wb_aluout_d, data_addr_q, data_addr_d;
  logic wb_adel_q, wb_adel_d, wb_ades_q, wb_ades_d;
  logic data_req_q, data_req_d, data_wr_q, data_wr_d;
  logic [1:0] data_size_q, data_size_d;
  logic [3:0] data_wstrb_q, data_wstrb_d, strb;
  logic [DATA_W-1:0] wrep;
  logic mis, accept, go_req, done, imm;
  always_comb begin
    mis = (in_size == 2'b01 && in_addr[0]) || (in_size[1] && in_addr[1:0] != 2'b00);
    in_ready = state_q == IDLE && (!out_valid_q || wb_allowin);
    accept = in_valid && in_ready && !flush;
    go_req = accept && (in_load || in_store) && !mis;
    imm = accept && !go_req;
    done = state_q == WAIT && data_data_ok;
    strb = in_size == 2'b00 ? 4'b0001 << in_addr[1:0] :
           in_size == 2'b01 ? (in_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wrep = in_size == 2'b00 ? {4{in_wdata[7:0]}} :
           in_size == 2'b01 ? {2{in_wdata[15:0]}} : in_wdata;
    state_d = state_q == IDLE ? (go_req ? REQ : IDLE) :
              state_q == REQ  ? (data_addr_ok ? WAIT : REQ) :
                                (data_data_ok ? IDLE : WAIT);
    // a flush arriving together with data_ok still kills that completion
    discard_d = done ? 1'b0 : (flush && state_q != IDLE) ? 1'b1 : discard_q;
    out_valid_d = flush ? 1'b0 : (imm || (done && !discard_q)) ? 1'b1 : out_valid_q && !wb_allowin;
    wb_dmout_d = imm ? '0 : (done && !discard_q && !flush) ? (ld_q ? data_rdata : '0) : wb_dmout_q;
    wb_aluout_d = imm ? in_addr : (done && !discard_q && !flush) ? data_addr_q : wb_aluout_q;
    wb_adel_d = imm ? in_load && mis : (done && !discard_q && !flush) ? 1'b0 : wb_adel_q;
    wb_ades_d = imm ? in_store && mis : (done && !discard_q && !flush) ? 1'b0 : wb_ades_q;
    // request is never withdrawn once raised; only addr_ok drops it
    data_req_d = go_req ? 1'b1 : (state_q == REQ && data_addr_ok) ? 1'b0 : data_req_q;
    data_wr_d = go_req ? in_store : data_wr_q;
    data_size_d = go_req ? in_size : data_size_q;
    data_addr_d = go_req ? in_addr : data_addr_q;
    data_wstrb_d = go_req ? (in_store ? strb : 4'b0000) : data_wstrb_q;
    data_wdata_d = go_req ? wrep : data_wdata_q;
    ld_d = go_req ? in_load : ld_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      discard_q <= 1'b0;
      ld_q <= 1'b0;
      out_valid_q <= 1'b0;
      wb_dmout_q <= '0;
      wb_aluout_q <= '0;
      wb_adel_q <= 1'b0;
      wb_ades_q <= 1'b0;
      data_req_q <= 1'b0;
      data_wr_q <= 1'b0;
      data_size_q <= 2'b00;
      data_addr_q <= '0;
      data_wstrb_q <= 4'b0000;
      data_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      discard_q <= discard_d;
      ld_q <= ld_d;
      out_valid_q <= out_valid_d;
      wb_dmout_q <= wb_dmout_d;
      wb_aluout_q <= wb_aluout_d;
      wb_adel_q <= wb_adel_d;
      wb_ades_q <= wb_ades_d;
      data_req_q <= data_req_d;
      data_wr_q <= data_wr_d;
      data_size_q <= data_size_d;
      data_addr_q <= data_addr_d;
      data_wstrb_q <= data_wstrb_d;
      data_wdata_q <= data_wdata_d;
    end
  end
  assign out_valid = out_valid_q;
  assign wb_dmout = wb_dmout_q;
  assign wb_aluout = wb_aluout_q;
  assign wb_adel = wb_adel_q;
  assign wb_ades = wb_ades_q;
  assign data_req = data_req_q;
  assign data_wr = data_wr_q;
  assign data_size = data_size_q;
  assign data_addr = data_addr_q;
  assign data_wstrb = data_wstrb_q;
  assign data_wdata = data_wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit with directed scenarios and randomized traffic
module tb_mem_access_unit;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_load = 0, in_store = 0, flush = 0;
  logic [1:0] in_size = 0;
  logic [31:0] in_addr = 0, in_wdata = 0;
  logic out_valid, wb_allowin = 1, wb_adel, wb_ades;
  logic [31:0] wb_dmout, wb_aluout;
  logic data_req, data_wr, data_addr_ok = 0, data_data_ok = 0;
  logic [1:0] data_size;
  logic [31:0] data_addr, data_wdata, data_rdata = 0;
  logic [3:0] data_wstrb;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load),
    .in_store(in_store), .in_size(in_size), .in_addr(in_addr), .in_wdata(in_wdata),
    .flush(flush), .out_valid(out_valid), .wb_allowin(wb_allowin), .wb_dmout(wb_dmout),
    .wb_aluout(wb_aluout), .wb_adel(wb_adel), .wb_ades(wb_ades), .data_req(data_req),
    .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr), .data_wstrb(data_wstrb),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] dm; logic [31:0] alu; logic adel; logic ades;} out_t;
  typedef struct {logic wr; logic [1:0] size; logic [31:0] addr; logic [3:0] strb; logic [31:0] wdata;} req_t;
  out_t qout[$];
  req_t qreq[$];
  out_t mon_o;
  int checks = 0, fails = 0;
  bit done_stim = 0;
  logic [31:0] mem_img [logic [31:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return mem_img.exists(a) ? mem_img[a] : (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Reference: an access is misaligned when the address is not a multiple of its byte count;
  // a store writes nbytes consecutive lanes starting at addr%4, each lane carrying its byte of the datum.
  function automatic void model(input logic ld, input logic st, input logic [1:0] sz,
                                input logic [31:0] a, input logic [31:0] wd, input bit push_out);
    int nb, off;
    bit mis;
    out_t o;
    req_t r;
    nb = 1 << sz;
    off = int'(a[1:0]);
    mis = (off % nb) != 0;
    o.alu = a;
    o.adel = ld && mis;
    o.ades = st && mis;
    o.dm = (ld && !mis) ? rd_of(a) : 32'h0;
    if ((ld || st) && !mis) begin
      r.wr = st; r.size = sz; r.addr = a; r.strb = '0; r.wdata = '0;
      if (st)
        for (int b = 0; b < 4; b++) begin
          if (b >= off && b < off + nb) r.strb[b] = 1'b1;
          r.wdata[8*b +: 8] = wd[8*(b % nb) +: 8];
        end
      qreq.push_back(r);
    end
    if (push_out) qout.push_back(o);
  endfunction

  task automatic issue(input logic ld, input logic st, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input bit push_out);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1; in_load = ld; in_store = st; in_size = sz; in_addr = a; in_wdata = wd;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("accept", {31'b0, in_ready}, 32'd1);
    if (in_ready) model(ld, st, sz, a, wd, push_out);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  // Called at a negedge where a request is expected to be up.
  task automatic bus_serve(input int ad, input int dd);
    req_t r;
    chk("data_req_up", {31'b0, data_req}, 32'd1);
    repeat (ad) @(negedge clk);
    chk("data_req_held", {31'b0, data_req}, 32'd1);
    if (qreq.size() == 0) chk("req_expected", 32'(qreq.size()), 32'd1);
    else begin
      r = qreq.pop_front();
      chk("req_wr", {31'b0, data_wr}, {31'b0, r.wr});
      chk("req_size", {30'b0, data_size}, {30'b0, r.size});
      chk("req_addr", data_addr, r.addr);
      chk("req_wstrb", {28'b0, data_wstrb}, {28'b0, r.strb});
      if (r.wr) chk("req_wdata", data_wdata, r.wdata);
    end
    data_addr_ok = 1;
    @(negedge clk);
    data_addr_ok = 0;
    chk("data_req_drop", {31'b0, data_req}, 32'd0);
    repeat (dd) @(negedge clk);
    data_data_ok = 1;
    data_rdata = rd_of(data_addr);
    @(negedge clk);
    data_data_ok = 0;
    data_rdata = $urandom;
  endtask

  always @(negedge clk)
    if (!rst && out_valid && wb_allowin) begin
      if (qout.size() == 0) chk("unexpected_out", {31'b0, out_valid}, 32'd0);
      else begin
        mon_o = qout.pop_front();
        chk("wb_dmout", wb_dmout, mon_o.dm);
        chk("wb_aluout", wb_aluout, mon_o.alu);
        chk("wb_adel", {31'b0, wb_adel}, {31'b0, mon_o.adel});
        chk("wb_ades", {31'b0, wb_ades}, {31'b0, mon_o.ades});
      end
    end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_data_req", {31'b0, data_req}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_wstrb", {28'b0, data_wstrb}, 32'd0);
    chk("rst_dmout", wb_dmout, 32'd0);
    // 1: plain load
    mem_img[32'h100] = 32'hDEADBEEF;
    issue(1, 0, 2'b10, 32'h100, 0, 1);
    @(negedge clk);
    bus_serve(0, 0);
    chk("t1_out_valid", {31'b0, out_valid}, 32'd1);
    // 2: byte store at lane 3
    issue(0, 1, 2'b00, 32'h203, 32'h000000A5, 1);
    @(negedge clk);
    bus_serve(1, 0);
    chk("t2_out_valid", {31'b0, out_valid}, 32'd1);
    // 3: misaligned accesses finish without a request
    issue(1, 0, 2'b01, 32'h101, 0, 1);
    chk("t3_lh_noreq", {31'b0, data_req}, 32'd0);
    chk("t3_lh_valid", {31'b0, out_valid}, 32'd1);
    issue(0, 1, 2'b10, 32'h102, 32'h12345678, 1);
    chk("t3_sw_noreq", {31'b0, data_req}, 32'd0);
    chk("t3_sw_valid", {31'b0, out_valid}, 32'd1);
    repeat (2) @(negedge clk);
    // 4: flush while waiting for data
    issue(1, 0, 2'b10, 32'h500, 0, 0);
    @(negedge clk);
    chk("t4_req", {31'b0, data_req}, 32'd1);
    qreq.delete(0);
    data_addr_ok = 1;
    @(negedge clk);
    data_addr_ok = 0;
    flush = 1;
    @(negedge clk);
    flush = 0;
    in_valid = 1; in_load = 0; in_store = 0; in_size = 0; in_addr = 32'h504;
    for (int i = 0; i < 2; i++) begin
      chk("t4_stall_ready", {31'b0, in_ready}, 32'd0);
      chk("t4_stall_valid", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
    end
    chk("t4_ready_at_ok", {31'b0, in_ready}, 32'd0);
    data_data_ok = 1;
    data_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    data_data_ok = 0;
    chk("t4_discarded", {31'b0, out_valid}, 32'd0);
    chk("t4_ready_after", {31'b0, in_ready}, 32'd1);
    if (in_ready) model(0, 0, 2'b00, 32'h504, 0, 1);
    @(posedge clk); #1;
    in_valid = 0;
    repeat (2) @(negedge clk);
    // 5: completion held while WB stalls
    wb_allowin = 0;
    issue(1, 0, 2'b10, 32'h300, 0, 1);
    @(negedge clk);
    bus_serve(1, 1);
    @(posedge clk); #1;
    in_valid = 1; in_load = 1; in_store = 0; in_size = 2'b10; in_addr = 32'h304;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("t5_hold_ready", {31'b0, in_ready}, 32'd0);
      chk("t5_hold_dmout", wb_dmout, rd_of(32'h300));
      chk("t5_hold_alu", wb_aluout, 32'h300);
    end
    @(posedge clk); #1;
    wb_allowin = 1;
    @(negedge clk);
    chk("t5_same_cycle_accept", {31'b0, in_ready}, 32'd1);
    if (in_ready) model(1, 0, 2'b10, 32'h304, 0, 1);
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    bus_serve(0, 0);
    repeat (2) @(negedge clk);
    // 6: reset in the middle of a request
    issue(1, 0, 2'b10, 32'h400, 0, 0);
    @(negedge clk);
    chk("t6_req", {31'b0, data_req}, 32'd1);
    rst = 1;
    #1;
    chk("t6_rst_req", {31'b0, data_req}, 32'd0);
    chk("t6_rst_valid", {31'b0, out_valid}, 32'd0);
    qreq.delete();
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("t6_ready", {31'b0, in_ready}, 32'd1);
    chk("t6_req_low", {31'b0, data_req}, 32'd0);
    chk("t6_valid_low", {31'b0, out_valid}, 32'd0);
    // random traffic
    fork
      begin
        for (int k = 0; k < 80; k++) begin
          int kind;
          kind = $urandom_range(0, 4);
          issue(kind < 2, kind == 2 || kind == 3, 2'($urandom_range(0, 2)),
                $urandom & 32'h0000FFFF, $urandom, 1);
          repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        done_stim = 1;
      end
      begin
        while (!done_stim) begin
          @(posedge clk); #1;
          wb_allowin = $urandom_range(0, 3) != 0;
        end
        wb_allowin = 1;
      end
      begin
        int idle = 0;
        while ((!done_stim || qreq.size() != 0) && idle < 500) begin
          @(negedge clk);
          if (done_stim) idle++;
          if (data_req) bus_serve($urandom_range(0, 2), $urandom_range(0, 2));
        end
      end
    join
    wb_allowin = 1;
    repeat (5) @(negedge clk);
    chk("qout_drained", 32'(qout.size()), 32'd0);
    chk("qreq_drained", 32'(qreq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
